// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer generators: pointer width helper,
// power-of-two detection and the binary-to-Gray conversion.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;
  localparam int GRAY_MAX_W     = 32;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Callers zero-extend into and truncate out of the fixed 32-bit carrier.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_gen.sv
// FIFO pointer generator: {wrap, index} binary pointer with any depth up to
// 2^ADDR_WIDTH, a same-edge Gray copy for CDC, wrap pulse and load-range error.
module fifo_ptr_gen
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  i_Enable,
  input  logic                  i_Clear,
  input  logic                  i_Load,
  input  logic [ADDR_WIDTH:0]   i_Load_Value,
  output logic [ADDR_WIDTH:0]   o_Address,
  output logic [ADDR_WIDTH:0]   o_Address_Next,
  output logic [ADDR_WIDTH:0]   o_Gray,
  output logic                  o_Wrap_Pulse,
  output logic                  o_Load_Err
);

  localparam int                    PW         = ptr_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);
  localparam bit                    CARRY_WRAP = is_pow2(DEPTH) && (DEPTH == (1 << ADDR_WIDTH));

  generate
    if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("fifo_ptr_gen: DEPTH must lie in 2..2**ADDR_WIDTH");
    end
  endgenerate

  logic [PW-1:0]         addr_q, addr_d, addr_inc, addr_next;
  logic [PW-1:0]         gray_q, gray_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic                  load_err_q, load_err_d;
  logic [ADDR_WIDTH-1:0] idx_q, load_idx;
  logic                  wrap_bit_q, at_last;

  assign idx_q      = addr_q[ADDR_WIDTH-1:0];
  assign wrap_bit_q = addr_q[ADDR_WIDTH];
  assign load_idx   = i_Load_Value[ADDR_WIDTH-1:0];
  assign at_last    = (idx_q == LAST_IDX);

  // Full-range depths let the index carry ripple straight into the wrap bit.
  always_comb begin
    if (CARRY_WRAP) begin
      addr_inc = addr_q + PW'(1);
    end else if (at_last) begin
      addr_inc = {~wrap_bit_q, {ADDR_WIDTH{1'b0}}};
    end else begin
      addr_inc = {wrap_bit_q, idx_q + ADDR_WIDTH'(1)};
    end
  end

  always_comb begin
    addr_d       = addr_q;
    wrap_pulse_d = 1'b0;
    load_err_d   = 1'b0;
    if (i_Clear) begin
      addr_d = '0;
    end else if (i_Load) begin
      if (load_idx > LAST_IDX) begin
        addr_d     = {i_Load_Value[ADDR_WIDTH], LAST_IDX};
        load_err_d = 1'b1;
      end else begin
        addr_d = i_Load_Value;
      end
    end else if (i_Enable) begin
      addr_d       = addr_inc;
      wrap_pulse_d = at_last;
    end
  end

  // Reset is folded in so the Next output always predicts the following o_Address.
  assign addr_next = RST ? '0 : addr_d;
  assign gray_d    = PW'(bin2gray(GRAY_MAX_W'(addr_next)));

  always_ff @(posedge clk) begin
    if (RST) begin
      addr_q       <= '0;
      gray_q       <= '0;
      wrap_pulse_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      gray_q       <= gray_d;
      wrap_pulse_q <= wrap_pulse_d;
      load_err_q   <= load_err_d;
    end
  end

  assign o_Address      = addr_q;
  assign o_Address_Next = addr_next;
  assign o_Gray         = gray_q;
  assign o_Wrap_Pulse   = wrap_pulse_q;
  assign o_Load_Err     = load_err_q;

endmodule

// File: tb/tb_fifo_ptr_gen.sv
// Bench for fifo_ptr_gen: a full-range (DEPTH=8) and a non-power-of-two
// (DEPTH=6) instance share stimulus and are each tracked by an index/wrap model.
module tb_fifo_ptr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, clr = 1'b0, ld = 1'b0;
  logic [3:0] lv = '0;

  logic [3:0] a8, an8, g8, a6, an6, g6;
  logic       wp8, le8, wp6, le6;

  int n_checks = 0;
  int n_fail   = 0;

  // model state per instance: 0 -> DEPTH 8, 1 -> DEPTH 6
  int depth [2] = '{8, 6};
  int m_idx [2] = '{0, 0};
  int m_wrap[2] = '{0, 0};
  int m_wp  [2] = '{0, 0};
  int m_le  [2] = '{0, 0};

  always #5 clk = ~clk;

  fifo_ptr_gen #(.ADDR_WIDTH(3), .DEPTH(8)) dut8 (
    .clk(clk), .RST(rst), .i_Enable(en), .i_Clear(clr), .i_Load(ld),
    .i_Load_Value(lv), .o_Address(a8), .o_Address_Next(an8), .o_Gray(g8),
    .o_Wrap_Pulse(wp8), .o_Load_Err(le8)
  );

  fifo_ptr_gen #(.ADDR_WIDTH(3), .DEPTH(6)) dut6 (
    .clk(clk), .RST(rst), .i_Enable(en), .i_Clear(clr), .i_Load(ld),
    .i_Load_Value(lv), .o_Address(a6), .o_Address_Next(an6), .o_Gray(g6),
    .o_Wrap_Pulse(wp6), .o_Load_Err(le6)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  // Reference behaviour: index counts modulo DEPTH, wrap bit flips on roll-over.
  task automatic model_next(input int k, output int nidx, output int nwrap,
                            output int nwp, output int nle);
    int vi, vw;
    nidx = m_idx[k]; nwrap = m_wrap[k]; nwp = 0; nle = 0;
    if (rst || clr) begin
      nidx = 0; nwrap = 0;
    end else if (ld) begin
      vi = int'(lv) % 8;
      vw = int'(lv) / 8;
      nwrap = vw;
      if (vi >= depth[k]) begin
        nidx = depth[k] - 1; nle = 1;
      end else begin
        nidx = vi;
      end
    end else if (en) begin
      if (m_idx[k] + 1 == depth[k]) begin
        nidx = 0; nwrap = 1 - m_wrap[k]; nwp = 1;
      end else begin
        nidx = m_idx[k] + 1;
      end
    end
  endtask

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic cyc(input logic r, input logic c, input logic l,
                     input logic [3:0] v, input logic e);
    int ni[2], nw[2], np[2], nl[2];
    int exp_a;
    @(negedge clk);
    rst = r; clr = c; ld = l; lv = v; en = e;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_next(k, ni[k], nw[k], np[k], nl[k]);
    end
    chk("next8", int'(an8), nw[0] * 8 + ni[0]);
    chk("next6", int'(an6), nw[1] * 8 + ni[1]);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = ni[k]; m_wrap[k] = nw[k]; m_wp[k] = np[k]; m_le[k] = nl[k];
    end
    exp_a = m_wrap[0] * 8 + m_idx[0];
    chk("addr8", int'(a8), exp_a);
    chk("gray8", int'(g8), gray_of(exp_a));
    chk("wrap8", int'(wp8), m_wp[0]);
    chk("lerr8", int'(le8), m_le[0]);
    exp_a = m_wrap[1] * 8 + m_idx[1];
    chk("addr6", int'(a6), exp_a);
    chk("gray6", int'(g6), gray_of(exp_a));
    chk("wrap6", int'(wp6), m_wp[1]);
    chk("lerr6", int'(le6), m_le[1]);
  endtask

  initial begin
    logic [3:0] prev_g;
    logic       r_r, r_c, r_l, r_e;
    logic [3:0] r_v;

    // reset state
    cyc(1, 0, 0, 4'd0, 0);
    cyc(1, 0, 0, 4'd0, 1);
    chk("rst_addr8", int'(a8), 0);
    chk("rst_gray8", int'(g8), 0);
    chk("rst_wp8", int'(wp8), 0);
    chk("rst_le8", int'(le8), 0);

    // DEPTH 8: 17 enables run 0..15 then back to 0, one Gray bit per step
    prev_g = g8;
    for (int i = 1; i <= 17; i++) begin
      cyc(0, 0, 0, 4'd0, 1);
      chk("seq8", int'(a8), i % 16);
      chk("wp8_seq", int'(wp8), (i == 8 || i == 16) ? 1 : 0);
      chk("gray_step8", $countones(g8 ^ prev_g), 1);
      prev_g = g8;
    end

    // DEPTH 6: index 0..5 twice, wrap bit flips at each 5 -> 0
    cyc(0, 1, 0, 4'd0, 1);
    chk("clr6", int'(a6), 0);
    for (int i = 1; i <= 13; i++) begin
      cyc(0, 0, 0, 4'd0, 1);
      chk("seq6", int'(a6), ((i / 6) % 2) * 8 + (i % 6));
      chk("idx6_range", (int'(a6) % 8) < 6 ? 1 : 0, 1);
    end

    // out-of-range load clamps and flags for one cycle
    cyc(0, 0, 1, 4'b0111, 0);
    chk("clamp6", int'(a6), 5);
    chk("lerr6_hi", int'(le6), 1);
    chk("noclamp8", int'(a8), 7);
    cyc(0, 0, 0, 4'd0, 0);
    chk("lerr6_lo", int'(le6), 0);
    cyc(0, 0, 1, 4'b1011, 0);
    chk("load6", int'(a6), 11);
    chk("lerr6_ok", int'(le6), 0);

    // priority: clear over load over enable
    cyc(0, 0, 1, 4'd3, 0);
    cyc(0, 1, 1, 4'd6, 1);
    chk("prio_clr6", int'(a6), 0);
    chk("prio_clr8", int'(a8), 0);
    cyc(0, 0, 1, 4'd2, 1);
    chk("prio_ld6", int'(a6), 2);
    chk("prio_ld8", int'(a8), 2);

    // reset wins over enable; first advance after release
    cyc(0, 0, 1, 4'd7, 0);
    cyc(1, 0, 0, 4'd0, 1);
    chk("midrst_addr8", int'(a8), 0);
    chk("midrst_gray8", int'(g8), 0);
    chk("midrst_le6", int'(le6), 0);
    cyc(0, 0, 0, 4'd0, 1);
    chk("post_rst8", int'(a8), 1);

    // random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      r_r = ($urandom_range(0, 199) == 0);
      r_c = ($urandom_range(0, 19) == 0);
      r_l = ($urandom_range(0, 9) == 0);
      r_e = ($urandom_range(0, 3) != 0);
      r_v = 4'($urandom_range(0, 15));
      cyc(r_r, r_c, r_l, r_v, r_e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
